// File: rtl/idac_code_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idac_code_seq_pkg
// Description : Shared types, default widths and the code clamp helper for
//               the multi-channel IDAC code sequencer.
//               Optional feature macro (used by the design files):
//               IDAC_CODE_SEQ_ONESHOT_EN
// Revision    : 1.0 - initial release
// ============================================================================
package idac_code_seq_pkg;

    localparam int              C_W_DEF        = 8;
    localparam int              C_NCH_DEF      = 2;
    localparam int              C_DW_DEF       = 16;
    localparam logic [15:0]     C_RST_CODE_DEF = 16'h007F;
    // Widest code the clamp helper handles; callers cast to and from it.
    localparam int              C_MAX_W        = 32;

    // Per-channel sequencing mode as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_UP   = 2'd1,
        MODE_DOWN = 2'd2,
        MODE_TRI  = 2'd3
    } mode_t;

    // Current travel direction of a channel.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Channel state: idle until the first start, then holding or moving.
    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_HOLD = 2'd1,
        CH_UP   = 2'd2,
        CH_DOWN = 2'd3
    } chan_st_t;

    // Clamp a code into [lo,hi]; an inverted range leaves the code untouched.
    function automatic logic [C_MAX_W-1:0] clamp_code(
        input logic [C_MAX_W-1:0] code,
        input logic [C_MAX_W-1:0] lo,
        input logic [C_MAX_W-1:0] hi
    );
        logic [C_MAX_W-1:0] res;
        res = code;
        if (lo <= hi) begin
            if (code < lo) begin
                res = lo;
            end else if (code > hi) begin
                res = hi;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idac_code_seq_chan.sv
`default_nettype none
// ============================================================================
// Module      : idac_code_chan
// Description : One IDAC sequencer channel: code register, direction state
//               and the step / wrap / turn-around arithmetic, advanced by the
//               shared tick strobe from the top-level prescaler.
//               Optional feature macro: IDAC_CODE_SEQ_ONESHOT_EN
//               (UP/DOWN saturate at the limit and raise a sticky done).
// Revision    : 1.0 - initial release
// ============================================================================
module idac_code_chan
    import idac_code_seq_pkg::*;
#(
    parameter int           W   = C_W_DEF,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         tick,
    input  logic [1:0]   mode,
    input  logic [W-1:0] step,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] init,
    output logic [W-1:0] code,
    output logic         done
);

    chan_st_t     r_state;
    chan_st_t     w_state_nxt;
    logic [W-1:0] r_code;
    logic [W-1:0] w_code_nxt;
    logic [W-1:0] w_init_clamp;
    logic [W:0]   w_sum;
    logic [W:0]   w_lo_step;
    logic [W:0]   w_code_ext;
    logic [W:0]   w_hi_ext;
    logic         w_frozen;
    mode_t        w_mode;
    dir_t         w_dir;

    assign w_mode       = mode_t'(mode);
    assign w_init_clamp = W'(clamp_code(C_MAX_W'(init), C_MAX_W'(lo), C_MAX_W'(hi)));
    // One extra bit so limit comparisons never see a wrapped sum.
    assign w_code_ext   = {1'b0, r_code};
    assign w_hi_ext     = {1'b0, hi};
    assign w_sum        = w_code_ext + {1'b0, step};
    assign w_lo_step    = {1'b0, lo} + {1'b0, step};
    // A zero step or an inverted range parks the channel without touching
    // its direction.
    assign w_frozen     = (step == '0) || (lo > hi);
    // A channel arriving in TRI from HOLD starts upward.
    assign w_dir        = (r_state == CH_DOWN) ? DIR_DOWN : DIR_UP;
    assign code         = r_code;

`ifdef IDAC_CODE_SEQ_ONESHOT_EN
    logic r_done;
    logic w_done_nxt;
    assign done = r_done;
`else
    assign done = 1'b0;
`endif

    // Next code and state: start reloads, otherwise step on tick.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
`ifdef IDAC_CODE_SEQ_ONESHOT_EN
        w_done_nxt  = r_done;
`endif
        if (start) begin
            w_code_nxt = w_init_clamp;
`ifdef IDAC_CODE_SEQ_ONESHOT_EN
            w_done_nxt = 1'b0;
`endif
            case (w_mode)
                MODE_UP, MODE_TRI: w_state_nxt = CH_UP;
                MODE_DOWN:         w_state_nxt = CH_DOWN;
                default:           w_state_nxt = CH_HOLD;
            endcase
        end else if (tick && (r_state != CH_IDLE)) begin
            case (w_mode)
                MODE_UP: begin
                    if (!w_frozen) begin
                        w_state_nxt = CH_UP;
`ifdef IDAC_CODE_SEQ_ONESHOT_EN
                        if (!r_done) begin
                            if (w_sum >= w_hi_ext) begin
                                w_code_nxt = hi;
                                w_done_nxt = 1'b1;
                            end else begin
                                w_code_nxt = w_sum[W-1:0];
                            end
                        end
`else
                        if (w_sum > w_hi_ext) begin
                            w_code_nxt = lo;
                        end else begin
                            w_code_nxt = w_sum[W-1:0];
                        end
`endif
                    end
                end
                MODE_DOWN: begin
                    if (!w_frozen) begin
                        w_state_nxt = CH_DOWN;
`ifdef IDAC_CODE_SEQ_ONESHOT_EN
                        if (!r_done) begin
                            if (w_code_ext <= w_lo_step) begin
                                w_code_nxt = lo;
                                w_done_nxt = 1'b1;
                            end else begin
                                w_code_nxt = r_code - step;
                            end
                        end
`else
                        if (w_code_ext < w_lo_step) begin
                            w_code_nxt = hi;
                        end else begin
                            w_code_nxt = r_code - step;
                        end
`endif
                    end
                end
                MODE_TRI: begin
                    if (!w_frozen) begin
                        if (w_dir == DIR_UP) begin
                            if (w_sum >= w_hi_ext) begin
                                w_code_nxt  = hi;
                                w_state_nxt = CH_DOWN;
                            end else begin
                                w_code_nxt  = w_sum[W-1:0];
                                w_state_nxt = CH_UP;
                            end
                        end else begin
                            if (w_code_ext <= w_lo_step) begin
                                w_code_nxt  = lo;
                                w_state_nxt = CH_UP;
                            end else begin
                                w_code_nxt  = r_code - step;
                                w_state_nxt = CH_DOWN;
                            end
                        end
                    end
                end
                default: w_state_nxt = CH_HOLD;
            endcase
        end
    end

    // Channel state and code registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CH_IDLE;
            r_code  <= RST;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
        end
    end

`ifdef IDAC_CODE_SEQ_ONESHOT_EN
    // Sticky limit-reached flag, cleared by start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/idac_code_seq.sv
`default_nettype none
// ============================================================================
// Module      : idac_code_seq
// Description : Multi-channel IDAC code sequencer. A shared dwell prescaler
//               produces the step instant; each channel steps its own code
//               in HOLD / UP / DOWN / TRI mode within live [lo,hi] limits.
//               Optional feature macro: IDAC_CODE_SEQ_ONESHOT_EN
//               (UP/DOWN channels stop at their limit; busy then drops).
// Revision    : 1.0 - initial release
// ============================================================================
module idac_code_seq
    import idac_code_seq_pkg::*;
#(
    parameter int                 W        = C_W_DEF,
    parameter int                 NCH      = C_NCH_DEF,
    parameter int                 DW       = C_DW_DEF,
    parameter logic [NCH*W-1:0]   RST_CODE = C_RST_CODE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 start,
    input  logic [DW-1:0]        dwell,
    input  logic [2*NCH-1:0]     mode,
    input  logic [W*NCH-1:0]     step,
    input  logic [W*NCH-1:0]     lo,
    input  logic [W*NCH-1:0]     hi,
    input  logic [W*NCH-1:0]     init,
    output logic [W*NCH-1:0]     code,
    output logic                 tick,
    output logic                 busy,
    output logic [NCH-1:0]       done
);

    logic [DW-1:0] r_cnt;
    logic          r_tick;
    logic          r_busy;
    logic          w_tick;
    logic          w_busy_clear;

    // Terminal count; >= keeps the prescaler sane if dwell shrinks mid-run.
    assign w_tick = r_busy && en && (r_cnt >= dwell);
    assign tick   = r_tick;
    assign busy   = r_busy;

`ifdef IDAC_CODE_SEQ_ONESHOT_EN
    logic w_any_os;
    logic w_all_done;

    // Busy ends once every UP/DOWN channel has reached its limit.
    always_comb begin
        w_any_os   = 1'b0;
        w_all_done = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if ((mode[2*i +: 2] == MODE_UP) || (mode[2*i +: 2] == MODE_DOWN)) begin
                w_any_os = 1'b1;
                if (!done[i]) begin
                    w_all_done = 1'b0;
                end
            end
        end
    end
    assign w_busy_clear = w_any_os && w_all_done;
`else
    assign w_busy_clear = 1'b0;
`endif

    // Dwell prescaler, registered tick and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_busy <= 1'b1;
        end else begin
            r_tick <= w_tick;
            if (r_busy && en) begin
                r_cnt <= w_tick ? '0 : r_cnt + DW'(1);
            end
            if (w_busy_clear) begin
                r_busy <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        idac_code_chan #(
            .W   (W),
            .RST (RST_CODE[g*W +: W])
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .start (start),
            .tick  (w_tick),
            .mode  (mode[2*g +: 2]),
            .step  (step[g*W +: W]),
            .lo    (lo[g*W +: W]),
            .hi    (hi[g*W +: W]),
            .init  (init[g*W +: W]),
            .code  (code[g*W +: W]),
            .done  (done[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_idac_code_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_idac_code_seq
// Description : Directed self-checking bench for idac_code_seq (default
//               build, IDAC_CODE_SEQ_ONESHOT_EN undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idac_code_seq;

    localparam int W   = 8;
    localparam int NCH = 2;
    localparam int DW  = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic               start;
    logic [DW-1:0]      dwell;
    logic [2*NCH-1:0]   mode;
    logic [W*NCH-1:0]   step;
    logic [W*NCH-1:0]   lo;
    logic [W*NCH-1:0]   hi;
    logic [W*NCH-1:0]   init;
    logic [W*NCH-1:0]   code;
    logic               tick;
    logic               busy;
    logic [NCH-1:0]     done;

    int n_tests = 0;
    int n_fail  = 0;

    always #50 clk = ~clk;

    idac_code_seq #(
        .W        (W),
        .NCH      (NCH),
        .DW       (DW),
        .RST_CODE (16'h007F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .start (start),
        .dwell (dwell),
        .mode  (mode),
        .step  (step),
        .lo    (lo),
        .hi    (hi),
        .init  (init),
        .code  (code),
        .tick  (tick),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Directed sequence; inputs change and outputs are sampled on negedge.
    initial begin
        logic [7:0]  tri_exp [6];
        logic [7:0]  dn_exp  [5];
        logic [15:0] e;
        tri_exp = '{8'h06, 8'h0A, 8'h06, 8'h02, 8'h06, 8'h0A};
        dn_exp  = '{8'h06, 8'h03, 8'h00, 8'h09, 8'h06};

        // Reset with start held high: start must be ignored.
        reset = 1'b1; start = 1'b1; en = 1'b1; dwell = '0; mode = '0;
        step = '0; lo = '0; hi = 16'hFFFF; init = 16'h1234;
        @(negedge clk);
        cyc(2);
        chk("rst_code", code, 16'h007F);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_done", done, 0);
        reset = 1'b0; start = 1'b0;
        cyc(2);
        chk("idle_code", code, 16'h007F);
        chk("idle_busy", busy, 0);

        // Fine ramp: ch1 UP step 1 over the full range, ch0 HOLD.
        mode = 4'b0100; step = 16'h0100; lo = '0; hi = 16'hFFFF;
        init = 16'h0033; dwell = '0;
        pulse_start();
        chk("ramp_start_code", code, 16'h0033);
        chk("ramp_start_busy", busy, 1);
        chk("ramp_start_tick", tick, 0);
        for (int k = 1; k <= 257; k++) begin
            cyc(1);
            e = {8'(k), 8'h33};
            chk("ramp_code", code, e);
            if (k == 1 || k == 257) chk("ramp_tick", tick, 1);
        end

        // Dwell 3 and en freeze: ch0 UP step 5 within [10,20].
        mode = 4'b0001; step = 16'h0005; lo = 16'h000A; hi = 16'hFF14;
        init = 16'h440A; dwell = 16'd3;
        pulse_start();
        chk("dw_start", code, 16'h440A);
        cyc(3);
        chk("dw_n3_code", code, 16'h440A);
        chk("dw_n3_tick", tick, 0);
        cyc(1);
        chk("dw_n4_code", code, 16'h440F);
        chk("dw_n4_tick", tick, 1);
        cyc(1);
        chk("dw_n5_tick", tick, 0);
        cyc(1);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("frz_code", code, 16'h440F);
            chk("frz_tick", tick, 0);
        end
        en = 1'b1;
        cyc(1);
        chk("res_n14_code", code, 16'h440F);
        chk("res_n14_tick", tick, 0);
        cyc(1);
        chk("res_n15_code", code, 16'h4414);
        chk("res_n15_tick", tick, 1);
        cyc(4);
        chk("res_wrap_code", code, 16'h440A);
        chk("res_wrap_tick", tick, 1);

        // Triangle: ch0 TRI step 4 within [2,10].
        mode = 4'b0011; step = 16'h0004; lo = 16'h0002; hi = 16'hFF0A;
        init = 16'h1202; dwell = '0;
        pulse_start();
        chk("tri_start", code, 16'h1202);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            e = {8'h12, tri_exp[i]};
            chk("tri_code", code, e);
        end

        // Zero step: code constant while ticking.
        mode = 4'b0001; step = '0; lo = '0; hi = 16'hFFFF; init = 16'h0055;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("step0_code", code, 16'h0055);
            chk("step0_tick", tick, 1);
        end

        // Inverted range mid-run: channel parks at its last code.
        step = 16'h0001; lo = 16'h000A; hi = 16'hFF3C; init = 16'h0019;
        pulse_start();
        chk("inv_start", code, 16'h0019);
        cyc(2);
        chk("inv_run", code, 16'h001B);
        lo = 16'h001E; hi = 16'hFF14;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("inv_hold", code, 16'h001B);
        end

        // Init above hi is clamped; start mid-run reloads and resets prescaler.
        lo = '0; hi = 16'hFF64; init = 16'h00C8; step = 16'h0001; dwell = 16'd5;
        pulse_start();
        chk("clamp_code", code, 16'h0064);
        chk("clamp_tick", tick, 0);
        cyc(3);
        init = 16'h0032;
        pulse_start();
        chk("restart_code", code, 16'h0032);
        chk("restart_tick", tick, 0);
        cyc(5);
        chk("restart_n5_code", code, 16'h0032);
        chk("restart_n5_tick", tick, 0);
        cyc(1);
        chk("restart_n6_code", code, 16'h0033);
        chk("restart_n6_tick", tick, 1);

        // DOWN wraps to hi in the default build; done stays low.
        mode = 4'b0010; step = 16'h0003; lo = '0; hi = 16'hFF09;
        init = 16'h0009; dwell = '0;
        pulse_start();
        chk("dn_start", code, 16'h0009);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            e = {8'h00, dn_exp[i]};
            chk("dn_code", code, e);
        end
        chk("dn_done", done, 0);
        chk("dn_busy", busy, 1);

        // Reset mid-sequence returns straight to reset values.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("mid_rst_code", code, 16'h007F);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tick", tick, 0);
        cyc(3);
        chk("post_rst_code", code, 16'h007F);
        chk("post_rst_tick", tick, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
